// File: rtl/hazard_pkg.sv
// Shared types and sizing for the pipeline hazard/sequencing controller.
package hazard_pkg;

  localparam int unsigned REG_W  = 4;
  localparam int unsigned NREG   = 16;
  localparam int unsigned PEND_W = 2;

  localparam logic [REG_W-1:0] R0 = '0;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  // Load currently sitting in EX (source of a load-use bubble)
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
  } ld_trk_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register pending-write counters. R0 is never counted.
// Simultaneous increment and decrement of one register cancel out;
// overflow/underflow are protocol errors that saturate.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned P_NREG   = NREG,
  parameter int unsigned P_PEND_W = PEND_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_inc_en,
  input  logic [REG_W-1:0]  i_inc_reg,
  input  logic              i_dec_en,
  input  logic [REG_W-1:0]  i_dec_reg,
  output logic [P_NREG-1:0] o_pending,
  output logic              o_all_clear
);

  localparam logic [P_PEND_W-1:0] CNT_MAX = '1;

  logic [P_PEND_W-1:0] r_cnt     [P_NREG];
  logic [P_PEND_W-1:0] w_cnt_nxt [P_NREG];
  logic [P_NREG-1:0]   w_inc_hit;
  logic [P_NREG-1:0]   w_dec_hit;

  // One-hot decode of increment/decrement targets, R0 excluded
  always_comb begin
    w_inc_hit = '0;
    w_dec_hit = '0;
    for (int i = 1; i < int'(P_NREG); i++) begin
      w_inc_hit[i] = i_inc_en && (i_inc_reg == REG_W'(i));
      w_dec_hit[i] = i_dec_en && (i_dec_reg == REG_W'(i));
    end
  end

  // Saturating next count per register
  always_comb begin
    for (int i = 0; i < int'(P_NREG); i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (w_inc_hit[i] && !w_dec_hit[i] && (r_cnt[i] != CNT_MAX)) begin
        w_cnt_nxt[i] = r_cnt[i] + P_PEND_W'(1);
      end else if (!w_inc_hit[i] && w_dec_hit[i] && (r_cnt[i] != '0)) begin
        w_cnt_nxt[i] = r_cnt[i] - P_PEND_W'(1);
      end
    end
  end

  // Counter registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < int'(P_NREG); i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < int'(P_NREG); i++) r_cnt[i] <= w_cnt_nxt[i];
    end
  end

  // Pending vector and drain indication
  always_comb begin
    for (int i = 0; i < int'(P_NREG); i++) o_pending[i] = (r_cnt[i] != '0);
    o_all_clear = ~|o_pending;
  end

`ifndef SYNTHESIS
  // Overflow/underflow of a counter means the pipeline lost track of a write
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int i = 0; i < int'(P_NREG); i++) begin
        if (w_inc_hit[i] && !w_dec_hit[i]) assert (r_cnt[i] != CNT_MAX);
        if (w_dec_hit[i] && !w_inc_hit[i]) assert (r_cnt[i] != '0);
      end
    end
  end
`endif

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: stall/bubble/flush/freeze and halt drain.
// Build option FORWARDING_EN: with EX/MEM and MEM/WB forwarding only a
// load in EX creates a hazard; otherwise any pending write to a source does.
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_id_valid,
  input  logic             i_id_rdEn1,
  input  logic [REG_W-1:0] i_id_rdReg1,
  input  logic             i_id_rdEn2,
  input  logic [REG_W-1:0] i_id_rdReg2,
  input  logic             i_id_wrEn,
  input  logic [REG_W-1:0] i_id_wrReg,
  input  logic             i_id_memRd,
  input  logic             i_id_hlt,
  input  logic             i_ex_redirect,
  input  logic             i_wb_wrEn,
  input  logic [REG_W-1:0] i_wb_wrReg,
  input  logic             i_mem_busy,
  output logic             o_issue,
  output logic             o_stall,
  output logic             o_bubble,
  output logic             o_flush,
  output logic             o_freeze,
  output logic             o_hlt
);

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_init_mask;
  ld_trk_t         r_ld_trk;
  logic [NREG-1:0] w_pending;
  logic            w_all_clear;
  logic            w_active;
  logic            w_upd;
  logic            w_src1_hz;
  logic            w_src2_hz;
  logic            w_hazard;
  logic            w_inc_en;
  logic            w_dec_en;

  // Outputs stay quiet during reset and the cycle right after it
  assign w_active = ~i_rst & ~r_init_mask;
  assign w_upd    = w_active & ~i_mem_busy;

`ifdef FORWARDING_EN
  assign w_src1_hz = i_id_rdEn1 && (i_id_rdReg1 != R0) &&
                     r_ld_trk.valid && (i_id_rdReg1 == r_ld_trk.rd);
  assign w_src2_hz = i_id_rdEn2 && (i_id_rdReg2 != R0) &&
                     r_ld_trk.valid && (i_id_rdReg2 == r_ld_trk.rd);
`else
  assign w_src1_hz = i_id_rdEn1 && (i_id_rdReg1 != R0) && w_pending[i_id_rdReg1];
  assign w_src2_hz = i_id_rdEn2 && (i_id_rdReg2 != R0) && w_pending[i_id_rdReg2];
`endif

  assign w_hazard = i_id_valid & (w_src1_hz | w_src2_hz);

  assign w_inc_en = o_issue & i_id_wrEn & (i_id_wrReg != R0);
  assign w_dec_en = w_upd & i_wb_wrEn & (i_wb_wrReg != R0);

  hazard_scoreboard #(
    .P_NREG   (NREG),
    .P_PEND_W (PEND_W)
  ) u_scoreboard (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_inc_en    (w_inc_en),
    .i_inc_reg   (i_id_wrReg),
    .i_dec_en    (w_dec_en),
    .i_dec_reg   (i_wb_wrReg),
    .o_pending   (w_pending),
    .o_all_clear (w_all_clear)
  );

  // Halt state and init-mask registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_RUN;
      r_init_mask <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_init_mask <= 1'b0;
    end
  end

  // Priority resolution (freeze > redirect > hazard > issue) and halt FSM
  always_comb begin
    w_state_nxt = r_state;
    o_issue     = 1'b0;
    o_stall     = 1'b0;
    o_bubble    = 1'b0;
    o_flush     = 1'b0;
    o_freeze    = 1'b0;
    o_hlt       = 1'b0;
    if (w_active) begin
      unique case (r_state)
        ST_RUN: begin
          if (i_mem_busy) begin
            o_freeze = 1'b1;
            o_stall  = 1'b1;
          end else if (i_ex_redirect) begin
            o_flush  = 1'b1;
            o_bubble = 1'b1;
          end else if (w_hazard) begin
            o_stall  = 1'b1;
            o_bubble = 1'b1;
          end else if (i_id_valid) begin
            o_issue = 1'b1;
            if (i_id_hlt) w_state_nxt = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (i_mem_busy) begin
            o_freeze = 1'b1;
            o_stall  = 1'b1;
          end else begin
            o_stall  = 1'b1;
            o_bubble = 1'b1;
            if (w_all_clear) w_state_nxt = ST_HALTED;
          end
        end
        ST_HALTED: begin
          o_hlt = 1'b1;
          if (i_mem_busy) begin
            o_freeze = 1'b1;
            o_stall  = 1'b1;
          end else begin
            o_stall  = 1'b1;
            o_bubble = 1'b1;
          end
        end
        default: w_state_nxt = ST_RUN;
      endcase
    end
  end

  // EX-load tracker: follows the instruction entering EX, cleared by a bubble
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ld_trk <= '0;
    end else if (w_upd) begin
      if (o_bubble) begin
        r_ld_trk <= '0;
      end else begin
        r_ld_trk <= '{valid: o_issue & i_id_memRd & i_id_wrEn & (i_id_wrReg != R0),
                      rd:    i_id_wrReg};
      end
    end
  end

`ifndef SYNTHESIS
  // Halt is the youngest instruction, so nothing may redirect behind it;
  // a load in EX must also be counted by the scoreboard
  always_ff @(posedge i_clk) begin
    if (!i_rst && !r_init_mask) begin
      if (r_state != ST_RUN) assert (!i_ex_redirect);
      if (r_ld_trk.valid) assert (w_pending[r_ld_trk.rd]);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios then random traffic, checked
// against a model that tracks which destination registers occupy EX/MEM/WB.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       i_rst, i_id_valid, i_id_rdEn1, i_id_rdEn2, i_id_wrEn;
  logic [3:0] i_id_rdReg1, i_id_rdReg2, i_id_wrReg, i_wb_wrReg;
  logic       i_id_memRd, i_id_hlt, i_ex_redirect, i_wb_wrEn, i_mem_busy;
  logic       o_issue, o_stall, o_bubble, o_flush, o_freeze, o_hlt;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_id_valid    (i_id_valid),
    .i_id_rdEn1    (i_id_rdEn1),
    .i_id_rdReg1   (i_id_rdReg1),
    .i_id_rdEn2    (i_id_rdEn2),
    .i_id_rdReg2   (i_id_rdReg2),
    .i_id_wrEn     (i_id_wrEn),
    .i_id_wrReg    (i_id_wrReg),
    .i_id_memRd    (i_id_memRd),
    .i_id_hlt      (i_id_hlt),
    .i_ex_redirect (i_ex_redirect),
    .i_wb_wrEn     (i_wb_wrEn),
    .i_wb_wrReg    (i_wb_wrReg),
    .i_mem_busy    (i_mem_busy),
    .o_issue       (o_issue),
    .o_stall       (o_stall),
    .o_bubble      (o_bubble),
    .o_flush       (o_flush),
    .o_freeze      (o_freeze),
    .o_hlt         (o_hlt)
  );

  typedef struct packed {
    logic       v;
    logic       e1;
    logic [3:0] r1;
    logic       e2;
    logic [3:0] r2;
    logic       we;
    logic [3:0] wr;
    logic       ld;
    logic       ht;
  } ins_t;

  int n_total = 0;
  int n_bad   = 0;

  // Model: mode 0=running 1=draining 2=halted; slot 0=EX 1=MEM 2=WB
  int       m_mode = 0;
  bit       m_mask = 1'b0;
  bit       m_last_issue = 1'b0;
  bit       m_last_stall = 1'b0;
  bit       p_v  [3];
  bit       p_ld [3];
  logic [3:0] p_reg [3];

  task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%b exp=%b (issue,stall,bubble,flush,freeze,hlt) t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int occ(input logic [3:0] r);
    int c = 0;
    if (r == 4'd0) return 0;
    for (int k = 0; k < 3; k++) if (p_v[k] && p_reg[k] == r) c++;
    return c;
  endfunction

  function automatic ins_t mk(input bit v, input bit e1, input logic [3:0] r1,
                              input bit e2, input logic [3:0] r2, input bit we,
                              input logic [3:0] wr, input bit ld, input bit ht);
    ins_t x;
    x.v = v; x.e1 = e1; x.r1 = r1; x.e2 = e2; x.r2 = r2;
    x.we = we; x.wr = wr; x.ld = ld; x.ht = ht;
    return x;
  endfunction

  function automatic ins_t rnd_ins();
    ins_t x;
    x.v  = ($urandom_range(0, 99) < 85);
    x.e1 = 1'($urandom_range(0, 1));
    x.r1 = 4'($urandom_range(0, 7));
    x.e2 = 1'($urandom_range(0, 1));
    x.r2 = 4'($urandom_range(0, 7));
    x.ld = ($urandom_range(0, 99) < 40);
    x.we = x.ld ? 1'b1 : ($urandom_range(0, 99) < 70);
    x.wr = 4'($urandom_range(0, 7));
    x.ht = ($urandom_range(0, 99) < 3);
    if (x.ht) begin
      x.we = 1'b0;
      x.ld = 1'b0;
    end
    return x;
  endfunction

  // One clock: drive, predict, check mid-cycle, then advance the model
  task automatic step(input bit rst, input ins_t in, input bit redir, input bit busy,
                      input string tag);
    bit iss = 0, stl = 0, bub = 0, fls = 0, frz = 0, hl = 0, hz = 0;
    bit alldone;
    i_rst = rst;         i_id_valid = in.v;
    i_id_rdEn1 = in.e1;  i_id_rdReg1 = in.r1;
    i_id_rdEn2 = in.e2;  i_id_rdReg2 = in.r2;
    i_id_wrEn = in.we;   i_id_wrReg = in.wr;
    i_id_memRd = in.ld;  i_id_hlt = in.ht;
    i_ex_redirect = redir;
    i_mem_busy = busy;
    i_wb_wrEn = p_v[2];
    i_wb_wrReg = p_reg[2];
    if (!rst && !m_mask) begin
      hl = (m_mode == 2);
`ifdef FORWARDING_EN
      hz = in.v && ((in.e1 && in.r1 != 0 && p_v[0] && p_ld[0] && p_reg[0] == in.r1) ||
                    (in.e2 && in.r2 != 0 && p_v[0] && p_ld[0] && p_reg[0] == in.r2));
`else
      hz = in.v && ((in.e1 && occ(in.r1) > 0) || (in.e2 && occ(in.r2) > 0));
`endif
      if (busy) begin
        frz = 1; stl = 1;
      end else if (m_mode != 0) begin
        stl = 1; bub = 1;
      end else if (redir) begin
        fls = 1; bub = 1;
      end else if (hz) begin
        stl = 1; bub = 1;
      end else if (in.v) begin
        iss = 1;
      end
    end
    @(negedge clk);
    chk(tag, {o_issue, o_stall, o_bubble, o_flush, o_freeze, o_hlt},
        {iss, stl, bub, fls, frz, hl});
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 3; k++) begin p_v[k] = 0; p_ld[k] = 0; p_reg[k] = 4'd0; end
      m_mode = 0;
      m_mask = 1;
    end else if (m_mask) begin
      m_mask = 0;
    end else if (!busy) begin
      alldone = 1;
      for (int k = 0; k < 3; k++) if (p_v[k] && p_reg[k] != 4'd0) alldone = 0;
      if (m_mode == 1 && alldone) m_mode = 2;
      if (iss && in.ht) m_mode = 1;
      for (int k = 2; k > 0; k--) begin
        p_v[k] = p_v[k-1]; p_ld[k] = p_ld[k-1]; p_reg[k] = p_reg[k-1];
      end
      p_v[0]   = iss && in.we;
      p_ld[0]  = in.ld;
      p_reg[0] = in.wr;
    end
    m_last_issue = iss;
    m_last_stall = stl;
    #1;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, tag);
  endtask

  task automatic issue_until(input ins_t in, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      step(0, in, 0, 0, tag);
      if (m_last_issue) return;
    end
    chk({tag, "_timeout"}, {5'b0, m_last_issue}, 6'b000001);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    ins_t cur;
    int   halted_cnt = 0;
    bit   rs, rd, bz;

    for (int k = 0; k < 3; k++) begin p_v[k] = 0; p_ld[k] = 0; p_reg[k] = 4'd0; end
    i_rst = 1; i_id_valid = 0; i_id_rdEn1 = 0; i_id_rdReg1 = 0; i_id_rdEn2 = 0;
    i_id_rdReg2 = 0; i_id_wrEn = 0; i_id_wrReg = 0; i_id_memRd = 0; i_id_hlt = 0;
    i_ex_redirect = 0; i_wb_wrEn = 0; i_wb_wrReg = 0; i_mem_busy = 0;
    @(posedge clk);
    #1;

    // Reset quiet window, even with live inputs
    step(1, mk(1, 0, 0, 0, 0, 1, 2, 0, 0), 0, 1, "rst_busy");
    step(1, mk(1, 0, 0, 0, 0, 1, 2, 0, 0), 1, 0, "rst");
    step(0, mk(1, 0, 0, 0, 0, 1, 2, 0, 0), 0, 0, "post_rst");

    // Load R3 then use R3
    step(0, mk(1, 0, 0, 0, 0, 1, 3, 1, 0), 0, 0, "ld_r3");
    issue_until(mk(1, 1, 3, 0, 0, 0, 0, 0, 0), 8, "use_r3");
    idle(4, "idle_a");

    // R0 is never pending
    step(0, mk(1, 0, 0, 0, 0, 1, 0, 1, 0), 0, 0, "ld_r0");
    step(0, mk(1, 1, 0, 1, 0, 0, 0, 0, 0), 0, 0, "use_r0");
    idle(3, "idle_b");

    // Redirect squashes a halt in ID
    step(0, mk(1, 0, 0, 0, 0, 0, 0, 0, 1), 1, 0, "redir_hlt");
    idle(2, "idle_c");
    step(0, mk(1, 0, 0, 0, 0, 1, 1, 0, 0), 0, 0, "after_redir");
    idle(4, "idle_d");

    // Freeze in the middle of a load-use stall
    step(0, mk(1, 0, 0, 0, 0, 1, 4, 1, 0), 0, 0, "ld_r4");
    for (int i = 0; i < 3; i++) step(0, mk(1, 1, 4, 0, 0, 0, 0, 0, 0), 0, 1, "frz");
    issue_until(mk(1, 1, 4, 0, 0, 0, 0, 0, 0), 8, "frz_resume");
    idle(4, "idle_e");

    // Issue and retire of R7 in the same cycle
    step(0, mk(1, 0, 0, 0, 0, 1, 7, 0, 0), 0, 0, "w7a");
    idle(2, "idle_f");
    step(0, mk(1, 0, 0, 0, 0, 1, 7, 0, 0), 0, 0, "w7b");
    issue_until(mk(1, 0, 0, 1, 7, 0, 0, 0, 0), 8, "use_r7");
    idle(4, "idle_g");

    // Halt with nothing outstanding: two-cycle latency
    step(0, mk(1, 0, 0, 0, 0, 0, 0, 0, 1), 0, 0, "hlt_quick");
    idle(3, "hlt_quick_wait");
    step(1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, "rst_q");
    idle(1, "post_rst_q");

    // Halt with R5 and R6 still pending, then reset out of HALTED
    step(0, mk(1, 0, 0, 0, 0, 1, 5, 1, 0), 0, 0, "w5");
    step(0, mk(1, 0, 0, 0, 0, 1, 6, 0, 0), 0, 0, "w6");
    step(0, mk(1, 0, 0, 0, 0, 0, 0, 0, 1), 0, 0, "hlt_issue");
    for (int i = 0; i < 8; i++) step(0, mk(1, 0, 0, 0, 0, 1, 1, 0, 0), 0, 0, "drain");
    step(1, mk(1, 0, 0, 0, 0, 1, 1, 0, 0), 0, 0, "rst_hlt");
    step(0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, "post_rst_hlt");
    step(0, mk(1, 0, 0, 0, 0, 1, 1, 0, 0), 0, 0, "run_again");
    idle(4, "idle_h");

    // Random traffic
    cur = rnd_ins();
    for (int c = 0; c < 4000; c++) begin
      rs = (halted_cnt >= 4) || ($urandom_range(0, 199) == 0);
      if (!m_last_stall) cur = rnd_ins();
      bz = ($urandom_range(0, 99) < 15);
      rd = (m_mode == 0 && !rs) ? ($urandom_range(0, 99) < 8) : 1'b0;
      step(rs, cur, rd, bz, "rnd");
      halted_cnt = (m_mode == 2) ? halted_cnt + 1 : 0;
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
